axi_stream_insert_header: RTL and testbench
===========================================

AXI_STREAM_INSERT_HEADER -- requirements
Module: axi_stream_insert_header

Interface
REQ-001 SHALL have parameter DATA_WD, default 32, data bus width in bits (multiple of 8).
REQ-002 SHALL have parameter DATA_BYTE_WD, default DATA_WD/8, byte-lane count.
REQ-003 SHALL have ports, in order:
- clk  in  1  sole clock, all logic on rising edge
- rst_n  in  1  synchronous, active-high reset (asserted when 1)
- valid_in  in  1  data beat valid
- data_in  in  DATA_WD  data beat; byte lane i = data_in[8i+7:8i]; lane DATA_BYTE_WD-1 is first in stream order
- keep_in  in  DATA_BYTE_WD  valid byte lanes
- last_in  in  1  final beat of packet
- ready_in  out  1  data beat accepted when valid_in && ready_in
- valid_out  out  1  output beat valid
- data_out  out  DATA_WD  output beat
- keep_out  out  DATA_BYTE_WD  valid output lanes
- last_out  out  1  final output beat
- ready_out  in  1  downstream ready
- valid_insert  in  1  header valid
- header_insert  in  DATA_WD  header word
- keep_insert  in  DATA_BYTE_WD  valid header lanes
- ready_insert  out  1  header accepted when valid_insert && ready_insert

Function
REQ-004 SHALL emit, per packet, the valid header bytes followed by all valid data bytes, packed contiguously from the MSB lane down, with no gaps.
REQ-005 keep_insert SHALL be low-aligned contiguous (0000, 0001, 0011, 0111, 1111); valid header bytes are its low n lanes, n = popcount(keep_insert); n=0 means pass-through.
REQ-006 keep_in SHALL be 1111 on non-last beats and high-aligned contiguous (1000, 1100, 1110, 1111) on the last beat; other encodings are illegal.
REQ-007 States SHALL be IDLE, STREAM and FLUSH.
REQ-008 IDLE: ready_insert=1, ready_in=0; header handshake captures the n header bytes into a residual register (count r=n) and moves to STREAM.
REQ-009 STREAM: ready_insert=0; ready_in = !valid_out || ready_out.
REQ-010 STREAM, on each accepted non-last beat: output beat = {r residual bytes, top DATA_BYTE_WD-r data bytes}, keep_out=all ones; residual becomes the low r data bytes.
REQ-011 STREAM, on an accepted last beat with b valid bytes: if r+b <= DATA_BYTE_WD, emit one beat with the top r+b lanes kept, last_out=1, and go to IDLE; otherwise emit a full beat with last_out=0, keep r+b-DATA_BYTE_WD residual bytes, and go to FLUSH.
REQ-012 FLUSH: ready_in=0, ready_insert=0; emit the residual bytes high-aligned with matching keep_out and last_out=1, then go to IDLE.
REQ-013 Output SHALL be registered: valid_out rises the cycle after the producing input handshake.
REQ-014 While valid_out && !ready_out, data_out, keep_out, last_out and valid_out SHALL hold stable.
REQ-015 valid_out SHALL drop after a handshake unless a new beat is loaded in the same cycle; full throughput is one beat per cycle when ready_out=1.
REQ-016 Data arriving before the header SHALL be stalled (ready_in=0) and never dropped; a header arriving mid-packet SHALL be stalled until return to IDLE.
REQ-017 A header and a data beat presented in the same IDLE cycle: the header is accepted that cycle and the data beat in the next.

Reset
REQ-018 While rst_n=1 at a clock edge: state=IDLE, valid_out=0, last_out=0, keep_out=0, data_out=0, residual=0, ready_in=0, ready_insert=1 (in the following cycle).
REQ-019 Reset asserted mid-packet SHALL discard all in-flight data and residual bytes without emitting them.

Configuration
REQ-020 With macro AXIS_HDR_ZERO_PAD_EN defined, data_out lanes whose keep_out bit is 0 SHALL be driven to 0x00; without it, those lanes are don't-care and hold leftover data.

Verification
REQ-021 Data first: data AABBCCDD held 2 cycles, then header FFEEDDCC/0111; data EEFF0011, 22334455, 66778899, 00AABBCC (last, keep 1100) -> EEDDCCAA, BBCCDDEE, FF001122, 33445566, 77889900, then AA000000 (keep 1000, last).
REQ-022 Header and first data beat in the same cycle, same packet -> identical output, first valid_out 2 cycles after the header handshake.
REQ-023 Header first, held 2 cycles before data -> header accepted on the first cycle; ready_in rises next cycle; identical output.
REQ-024 keep_insert=0000 with data 11223344, 55667788 (last, 1111) -> passthrough of 2 beats; keep_insert=1111 -> header beat, 2 data beats, last beat keep 1111.
REQ-025 ready_out toggled 1,0,0,1 during REQ-021 -> no lost or duplicated beats; outputs stable while stalled.
REQ-026 keep_insert 0111 with single beat AABBCCDD (last, 1111) -> EEDDCCAA keep 1111, then BBCCDD00 keep 1110 last (zero lane with AXIS_HDR_ZERO_PAD_EN).

Source files
------------

// File: rtl/axi_stream_insert_header.sv
// axi_stream_insert_header: prepends a per-packet header (0..DATA_BYTE_WD bytes)
// to an AXI-Stream packet and re-packs the bytes contiguously from the MSB lane.
// Optional build macro AXIS_HDR_ZERO_PAD_EN: drive data_out lanes with keep_out=0 to 0x00.
// Note: rst_n is a synchronous, active-HIGH reset despite its name.
//
// state  | meaning
// IDLE   | waiting for a header; data is stalled
// STREAM | merging residual bytes with incoming data beats
// FLUSH  | emitting the residual bytes left over after the last beat
`timescale 1ns/1ps
module axi_stream_insert_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      header_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  output logic                    ready_insert
);

  localparam int CW = $clog2(2 * DATA_BYTE_WD + 1);
  localparam logic [CW-1:0] BYTES = CW'(DATA_BYTE_WD);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t                  state, state_nxt;
  logic [DATA_WD-1:0]      res, res_nxt;
  logic [CW-1:0]           res_cnt, cnt_nxt;
  logic [CW-1:0]           hdr_cnt, beat_cnt, sum_cnt;
  logic [2*DATA_WD-1:0]    cat_shift;
  logic [DATA_WD-1:0]      window, flush_data;
  logic                    out_free, load;
  logic [DATA_WD-1:0]      ld_data;
  logic [DATA_BYTE_WD-1:0] ld_keep;
  logic                    ld_last;

  function automatic logic [DATA_BYTE_WD-1:0] top_lanes(input logic [CW-1:0] k);
    logic [DATA_BYTE_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[i] = (i + int'(k)) >= DATA_BYTE_WD;
    return m;
  endfunction

`ifdef AXIS_HDR_ZERO_PAD_EN
  function automatic logic [DATA_WD-1:0] lane_mask(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction
`endif

  // Byte counts of the header and of the current data beat
  always_comb begin
    hdr_cnt  = '0;
    beat_cnt = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      hdr_cnt  = hdr_cnt + CW'(keep_insert[i]);
      beat_cnt = beat_cnt + CW'(keep_in[i]);
    end
  end

  // Residual (low res_cnt lanes of res) followed by the top data lanes;
  // leftover data lanes after an overflowing last beat are re-aligned to the MSB.
  assign sum_cnt    = res_cnt + beat_cnt;
  assign cat_shift  = {res, data_in} >> {res_cnt, 3'b000};
  assign window     = cat_shift[DATA_WD-1:0];
  assign flush_data = data_in << {BYTES - res_cnt, 3'b000};
  assign out_free   = !valid_out || ready_out;

  // Next-state, handshake and output-load decode
  always_comb begin
    state_nxt    = state;
    res_nxt      = res;
    cnt_nxt      = res_cnt;
    ready_in     = 1'b0;
    ready_insert = 1'b0;
    load         = 1'b0;
    ld_data      = window;
    ld_keep      = '1;
    ld_last      = 1'b0;
    case (state)
      IDLE: begin
        ready_insert = 1'b1;
        if (valid_insert) begin
          res_nxt   = header_insert;
          cnt_nxt   = hdr_cnt;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        ready_in = out_free;
        if (valid_in && out_free) begin
          load = 1'b1;
          if (!last_in) begin
            res_nxt = data_in;
          end else if (sum_cnt <= BYTES) begin
            ld_keep   = top_lanes(sum_cnt);
            ld_last   = 1'b1;
            res_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            res_nxt   = flush_data;
            cnt_nxt   = sum_cnt - BYTES;
            state_nxt = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          load      = 1'b1;
          ld_data   = res;
          ld_keep   = top_lanes(res_cnt);
          ld_last   = 1'b1;
          res_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, residual and registered output beat
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= IDLE;
      res       <= '0;
      res_cnt   <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else begin
      state   <= state_nxt;
      res     <= res_nxt;
      res_cnt <= cnt_nxt;
      if (load) begin
        valid_out <= 1'b1;
`ifdef AXIS_HDR_ZERO_PAD_EN
        data_out  <= ld_data & lane_mask(ld_keep);
`else
        data_out  <= ld_data;
`endif
        keep_out  <= ld_keep;
        last_out  <= ld_last;
      end else if (ready_out) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_insert_header.sv
// Directed bench for axi_stream_insert_header (32-bit bus, 4 lanes).
`timescale 1ns/1ps
module tb_axi_stream_insert_header;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        last_in = 1'b0;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out = 1'b1;
  logic        valid_insert = 1'b0;
  logic [31:0] header_insert = '0;
  logic [3:0]  keep_insert = '0;
  logic        ready_insert;

  always #5 clk = ~clk;

  axi_stream_insert_header #(.DATA_WD(32), .DATA_BYTE_WD(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out),
    .valid_insert(valid_insert), .header_insert(header_insert), .keep_insert(keep_insert),
    .ready_insert(ready_insert)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int hdr_cyc  = 0;
  int first_vo = 0;
  logic arm_vo = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lmask(input logic [3:0] k);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // ready_out pattern, one bit per cycle
  logic [3:0] ro_pat = 4'b1111;
  int         ro_idx = 0;
  initial forever begin
    @(posedge clk); #1;
    ready_out = ro_pat[ro_idx];
    ro_idx = (ro_idx + 1) % 4;
  end

  // Output monitor: collects handshaken beats and checks stability under backpressure
  logic [31:0] got_d[$];
  logic [3:0]  got_k[$];
  logic        got_l[$];
  logic        stall_p = 1'b0;
  logic [31:0] sd;
  logic [3:0]  sk;
  logic        sl;
  always @(negedge clk) begin
    if (rst_n) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p) begin
        check("hold_valid", 64'(valid_out), 64'd1);
        check("hold_data", 64'(data_out), 64'(sd));
        check("hold_keep", 64'(keep_out), 64'(sk));
        check("hold_last", 64'(last_out), 64'(sl));
      end
      if (arm_vo && valid_out) begin
        first_vo = cyc;
        arm_vo   = 1'b0;
      end
      if (valid_out && ready_out) begin
        got_d.push_back(data_out);
        got_k.push_back(keep_out);
        got_l.push_back(last_out);
      end
      stall_p = valid_out && !ready_out;
      sd = data_out;
      sk = keep_out;
      sl = last_out;
    end
  end

  logic [31:0] pk_d[$];
  logic [3:0]  pk_k[$];
  logic [31:0] exp_d[$];
  logic [3:0]  exp_k[$];
  logic        exp_l[$];

  task automatic add_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp_d.push_back(d);
    exp_k.push_back(k);
    exp_l.push_back(l);
  endtask

  task automatic send_hdr(input logic [31:0] h, input logic [3:0] k);
    int   t = 0;
    logic hs = 1'b0;
    header_insert = h;
    keep_insert   = k;
    valid_insert  = 1'b1;
    do begin
      @(negedge clk);
      hs = ready_insert;
      if (hs) hdr_cyc = cyc;
      @(posedge clk); #1;
      t++;
    end while (!hs && t < 200);
    valid_insert = 1'b0;
    if (!hs) check("hdr_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_pkt();
    for (int b = 0; b < pk_d.size(); b++) begin
      int   t = 0;
      logic hs = 1'b0;
      data_in  = pk_d[b];
      keep_in  = pk_k[b];
      last_in  = (b == pk_d.size() - 1);
      valid_in = 1'b1;
      do begin
        @(negedge clk);
        hs = ready_in;
        @(posedge clk); #1;
        t++;
      end while (!hs && t < 200);
      if (!hs) check("data_timeout", 64'd0, 64'd1);
    end
    valid_in = 1'b0;
    last_in  = 1'b0;
    pk_d.delete();
    pk_k.delete();
  endtask

  task automatic expect_out(input string tag);
    int t = 0;
    while (got_d.size() < exp_d.size() && t < 300) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_count"}, 64'(got_d.size()), 64'(exp_d.size()));
    for (int i = 0; i < exp_d.size(); i++) begin
      if (i < got_d.size()) begin
        check($sformatf("%s_d%0d", tag, i), 64'(got_d[i] & lmask(got_k[i])), 64'(exp_d[i]));
        check($sformatf("%s_k%0d", tag, i), 64'(got_k[i]), 64'(exp_k[i]));
        check($sformatf("%s_l%0d", tag, i), 64'(got_l[i]), 64'(exp_l[i]));
      end
    end
    got_d.delete(); got_k.delete(); got_l.delete();
    exp_d.delete(); exp_k.delete(); exp_l.delete();
  endtask

  // Packet and expected output shared by the header FFEEDDCC/0111 scenarios
  task automatic load_pkt21();
    pk_d = '{32'hAABBCCDD, 32'hEEFF0011, 32'h22334455, 32'h66778899, 32'h00AABBCC};
    pk_k = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hC};
    add_exp(32'hEEDDCCAA, 4'hF, 1'b0);
    add_exp(32'hBBCCDDEE, 4'hF, 1'b0);
    add_exp(32'hFF001122, 4'hF, 1'b0);
    add_exp(32'h33445566, 4'hF, 1'b0);
    add_exp(32'h77889900, 4'hF, 1'b0);
    add_exp(32'hAA000000, 4'h8, 1'b1);
  endtask

  task automatic run_data_first(input string tag);
    load_pkt21();
    fork
      send_pkt();
      begin
        @(negedge clk); check({tag, "_stall0"}, 64'(ready_in), 64'd0);
        @(posedge clk); #1;
        @(negedge clk); check({tag, "_stall1"}, 64'(ready_in), 64'd0);
        @(posedge clk); #1;
        send_hdr(32'hFFEEDDCC, 4'b0111);
        @(negedge clk); check({tag, "_hdr_blocked"}, 64'(ready_insert), 64'd0);
      end
    join
    expect_out(tag);
  endtask

  initial begin
    int start;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid_out", 64'(valid_out), 64'd0);
    check("rst_last_out", 64'(last_out), 64'd0);
    check("rst_keep_out", 64'(keep_out), 64'd0);
    check("rst_data_out", 64'(data_out), 64'd0);
    check("rst_ready_in", 64'(ready_in), 64'd0);
    check("rst_ready_insert", 64'(ready_insert), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;

    // Data presented two cycles before the header
    run_data_first("data_first");

    // Header and first data beat in the same cycle
    load_pkt21();
    arm_vo = 1'b1;
    fork
      send_hdr(32'hFFEEDDCC, 4'b0111);
      send_pkt();
    join
    expect_out("same_cycle");
    check("same_cycle_latency", 64'(first_vo - hdr_cyc), 64'd2);

    // Header first, data two cycles later
    load_pkt21();
    start = cyc;
    send_hdr(32'hFFEEDDCC, 4'b0111);
    check("hdr_first_accept", 64'(hdr_cyc), 64'(start));
    @(negedge clk); check("hdr_first_ready_in", 64'(ready_in), 64'd1);
    @(posedge clk); #1;
    send_pkt();
    expect_out("hdr_first");

    // Empty header: pass-through
    pk_d = '{32'h11223344, 32'h55667788};
    pk_k = '{4'hF, 4'hF};
    add_exp(32'h11223344, 4'hF, 1'b0);
    add_exp(32'h55667788, 4'hF, 1'b1);
    send_hdr(32'h12345678, 4'b0000);
    send_pkt();
    expect_out("hdr0");

    // Full-word header
    pk_d = '{32'h11223344, 32'h55667788};
    pk_k = '{4'hF, 4'hF};
    add_exp(32'h0A0B0C0D, 4'hF, 1'b0);
    add_exp(32'h11223344, 4'hF, 1'b0);
    add_exp(32'h55667788, 4'hF, 1'b1);
    send_hdr(32'h0A0B0C0D, 4'b1111);
    send_pkt();
    expect_out("hdr4");

    // Backpressure 1,0,0,1 on the data-first packet
    ro_pat = 4'b1001;
    run_data_first("bp");
    ro_pat = 4'b1111;

    // Last beat fits alongside residual (1 + 2 bytes)
    pk_d = '{32'h11223344, 32'h55667788};
    pk_k = '{4'hF, 4'hC};
    add_exp(32'h5A112233, 4'hF, 1'b0);
    add_exp(32'h44556600, 4'hE, 1'b1);
    send_hdr(32'hFFFFFF5A, 4'b0001);
    send_pkt();
    expect_out("fit3");

    // Last beat exactly fills the word (2 + 2 bytes)
    pk_d = '{32'hC0FFEE00};
    pk_k = '{4'hC};
    add_exp(32'hBEEFC0FF, 4'hF, 1'b1);
    send_hdr(32'h0000BEEF, 4'b0011);
    send_pkt();
    expect_out("fit4");

    // Reset mid-packet discards residual and in-flight beats
    send_hdr(32'h99887766, 4'b0111);
    data_in  = 32'h11111111;
    keep_in  = 4'hF;
    last_in  = 1'b0;
    valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    got_d.delete(); got_k.delete(); got_l.delete();
    @(negedge clk);
    check("midrst_valid_out", 64'(valid_out), 64'd0);
    check("midrst_ready_insert", 64'(ready_insert), 64'd1);
    check("midrst_ready_in", 64'(ready_in), 64'd0);
    @(posedge clk); #1;

    // Single-beat packet overflowing into a flush beat
    pk_d = '{32'hAABBCCDD};
    pk_k = '{4'hF};
    add_exp(32'hEEDDCCAA, 4'hF, 1'b0);
    add_exp(32'hBBCCDD00, 4'hE, 1'b1);
    send_hdr(32'hFFEEDDCC, 4'b0111);
    send_pkt();
    expect_out("single");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
